// File: rtl/div_stream_sequencer_if.sv
// rtl/div_stream_sequencer_if.sv - job request / quotient response handshake bundle
interface div_stream_sequencer_if #(
    parameter int BITWIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BITWIDTH-1:0]   dividend;
    logic [BITWIDTH-1:0]   divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [BITWIDTH+1:0]   quot;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot
    );
endinterface

// File: rtl/div_stream_sequencer.sv
// rtl/div_stream_sequencer.sv - runs a bipolar stochastic divider kernel through whole division jobs
module div_stream_sequencer #(
    parameter int BITWIDTH      = 8,
    parameter int DEPLOG_KERNEL = 1,
    parameter int WARMUP        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    div_stream_sequencer_if.slave    bus,
    output logic                     kern_rst_n,
    output logic                     kern_dividend,
    output logic                     kern_divisor,
    output logic [DEPLOG_KERNEL-1:0] kern_randNum,
    input  logic                     kern_quotient
);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;   // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    localparam int          STREAM_LEN = 1 << BITWIDTH;
    localparam logic [BITWIDTH+1:0] QUOT_BIAS = (BITWIDTH+2)'(STREAM_LEN);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARM, S_RUN, S_DONE} state_t;

    state_t              state;
    logic [BITWIDTH-1:0] dividend_off;
    logic [BITWIDTH-1:0] divisor_off;
    logic [BITWIDTH-1:0] cnt;
    logic [BITWIDTH-1:0] cnt_rev;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [BITWIDTH:0]   ones;
    logic [BITWIDTH:0]   ones_next;
    logic [31:0]         tick;
    logic                start_job;
    logic                run_last;
    logic                stream_step;
    logic                out_valid_r;
    logic [BITWIDTH+1:0] quot_r;

    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.quot      = quot_r;

    // Bit-reversed counter decorrelates the divisor stream from the dividend stream
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            cnt_rev[i] = cnt[BITWIDTH-1-i];
        end
    end

    // Next-state helpers: LFSR step, ones accumulation, job start and stream-cycle decode
    always_comb begin
        lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        ones_next   = ones + (BITWIDTH+1)'(kern_quotient);
        start_job   = bus.in_valid && bus.in_ready;
        run_last    = (state == S_RUN) && (tick == 32'(STREAM_LEN - 1));
        stream_step = (state == S_CLEAR) || (state == S_WARM) || ((state == S_RUN) && !run_last);
    end

    // Job FSM; every kernel-facing output is registered here for the cycle that follows the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            dividend_off  <= '0;
            divisor_off   <= '0;
            cnt           <= '0;
            lfsr          <= LFSR_SEED;
            ones          <= '0;
            tick          <= '0;
            out_valid_r   <= 1'b0;
            quot_r        <= '0;
            kern_rst_n    <= 1'b1;
            kern_dividend <= 1'b0;
            kern_divisor  <= 1'b0;
            kern_randNum  <= '0;
        end else if (start_job) begin
            // Offset-binary makes the comparator SNG see 0..2^BITWIDTH-1 monotonically
            state        <= S_CLEAR;
            dividend_off <= {~bus.dividend[BITWIDTH-1], bus.dividend[BITWIDTH-2:0]};
            divisor_off  <= {~bus.divisor[BITWIDTH-1], bus.divisor[BITWIDTH-2:0]};
            cnt          <= '0;
            lfsr         <= LFSR_SEED;
            ones         <= '0;
            out_valid_r  <= 1'b0;
            kern_rst_n   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_CLEAR: begin
                    state      <= S_WARM;
                    kern_rst_n <= 1'b1;
                    tick       <= '0;
                end
                S_WARM: begin
                    if (tick == 32'(WARMUP - 1)) begin
                        state <= S_RUN;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                S_RUN: begin
                    ones <= ones_next;
                    tick <= tick + 32'd1;
                    if (run_last) begin
                        state       <= S_DONE;
                        out_valid_r <= 1'b1;
                        quot_r      <= {ones_next, 1'b0} - QUOT_BIAS;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (stream_step) begin
                kern_dividend <= dividend_off > cnt;
                kern_divisor  <= divisor_off > cnt_rev;
                kern_randNum  <= lfsr[DEPLOG_KERNEL-1:0];
                cnt           <= cnt + 1'b1;
                lfsr          <= lfsr_next;
            end else if (state == S_RUN) begin
                kern_dividend <= 1'b0;
                kern_divisor  <= 1'b0;
                kern_randNum  <= '0;
            end
        end
    end
endmodule
